// File: rtl/aes_round_sequencer_if.sv
// Start/status/control bundle between the AES round sequencer (slave side)
// and the block requester / datapath (master side).
interface aes_round_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       KeyMuxSel;
  logic       InputMuxSel;
  logic       FinalRound;
  logic       StateEN;
  logic       SboxInputSelector;
  logic       LoadKeySchedule;
  logic       ShowRcon;
  logic       DoSR;
  logic       KeyRegEn;
  logic [7:0] Rcon;
  logic [3:0] Round;

  modport master (
    output start,
    input  busy, done, KeyMuxSel, InputMuxSel, FinalRound, StateEN,
           SboxInputSelector, LoadKeySchedule, ShowRcon, DoSR, KeyRegEn,
           Rcon, Round
  );

  modport slave (
    input  start,
    output busy, done, KeyMuxSel, InputMuxSel, FinalRound, StateEN,
           SboxInputSelector, LoadKeySchedule, ShowRcon, DoSR, KeyRegEn,
           Rcon, Round
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: IDLE/RUN FSM stepping NR rounds of SBOX_LATENCY+2 phases.
// Optional macro AES_SEQ_BACK_TO_BACK_EN lets a new block start in the final phase.
module aes_round_sequencer #(
  parameter int SBOX_LATENCY = 5,
  parameter int NR           = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.slave  bus
);
  localparam int ROUND_LEN = SBOX_LATENCY + 2;
  localparam int PW        = $clog2(ROUND_LEN);
  localparam logic [PW-1:0] LAST_PHASE = PW'(ROUND_LEN - 1);
  localparam logic [PW-1:0] SBOX_PHASE = PW'(2);
  localparam logic [3:0]    LAST_ROUND = 4'(NR);

  if (SBOX_LATENCY < 3 || SBOX_LATENCY > 14) begin : g_bad_sbox_latency
    $error("aes_round_sequencer: SBOX_LATENCY out of range 3..14");
  end
  if (NR < 1 || NR > 14) begin : g_bad_nr
    $error("aes_round_sequencer: NR out of range 1..14");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic key_mux_sel;
    logic input_mux_sel;
    logic final_round;
    logic state_en;
    logic sbox_sel;
    logic load_ks;
    logic show_rcon;
    logic do_sr;
    logic key_en;
  } ctl_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic ctl_t decode(input state_t st, input logic [PW-1:0] ph,
                                  input logic [3:0] rnd);
    ctl_t c;
    c = '0;
    if (st == RUN) begin
      c.state_en      = 1'b1;
      c.do_sr         = ph[0] && (ph != LAST_PHASE);
      c.sbox_sel      = (ph == SBOX_PHASE);
      c.key_en        = (ph != SBOX_PHASE);
      c.load_ks       = (ph == {PW{1'b0}}) || (ph == LAST_PHASE);
      c.show_rcon     = (ph == LAST_PHASE);
      c.input_mux_sel = (rnd == 4'd1);
      c.key_mux_sel   = (rnd == 4'd1) && (ph < PW'(2));
      c.final_round   = (rnd == LAST_ROUND);
    end else begin
      c = '0;
    end
    return c;
  endfunction

  state_t        state_r;
  logic [PW-1:0] phase_r;
  logic [3:0]    round_r;
  logic [7:0]    rcon_r;
  logic          busy_r;
  logic          done_r;
  ctl_t          ctl_r;

  state_t        nxt_state_s;
  logic [PW-1:0] nxt_phase_s;
  logic [3:0]    nxt_round_s;
  logic [7:0]    nxt_rcon_s;
  logic          nxt_done_s;

  // Next-state logic: phase/round counters and round-constant stepping.
  always_comb begin
    nxt_state_s = state_r;
    nxt_phase_s = phase_r;
    nxt_round_s = round_r;
    nxt_rcon_s  = rcon_r;
    nxt_done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          nxt_state_s = RUN;
          nxt_phase_s = '0;
          nxt_round_s = 4'd1;
          nxt_rcon_s  = 8'h01;
        end else begin
          nxt_state_s = IDLE;
        end
      end
      RUN: begin
        if (phase_r == LAST_PHASE) begin
          if (round_r == LAST_ROUND) begin
            nxt_done_s  = 1'b1;
            nxt_phase_s = '0;
            nxt_rcon_s  = 8'h01;
`ifdef AES_SEQ_BACK_TO_BACK_EN
            if (bus.start) begin
              nxt_state_s = RUN;
              nxt_round_s = 4'd1;
            end else begin
              nxt_state_s = IDLE;
              nxt_round_s = 4'd0;
            end
`else
            nxt_state_s = IDLE;
            nxt_round_s = 4'd0;
`endif
          end else begin
            nxt_phase_s = '0;
            nxt_round_s = round_r + 4'd1;
            nxt_rcon_s  = xtime(rcon_r);
          end
        end else begin
          nxt_phase_s = phase_r + PW'(1);
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_phase_s = '0;
        nxt_round_s = 4'd0;
        nxt_rcon_s  = 8'h01;
      end
    endcase
  end

  // FSM state and registered outputs; controls are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      phase_r <= '0;
      round_r <= 4'd0;
      rcon_r  <= 8'h01;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ctl_r   <= '0;
    end else begin
      state_r <= nxt_state_s;
      phase_r <= nxt_phase_s;
      round_r <= nxt_round_s;
      rcon_r  <= nxt_rcon_s;
      busy_r  <= (nxt_state_s == RUN);
      done_r  <= nxt_done_s;
      ctl_r   <= decode(nxt_state_s, nxt_phase_s, nxt_round_s);
    end
  end

  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.KeyMuxSel         = ctl_r.key_mux_sel;
  assign bus.InputMuxSel       = ctl_r.input_mux_sel;
  assign bus.FinalRound        = ctl_r.final_round;
  assign bus.StateEN           = ctl_r.state_en;
  assign bus.SboxInputSelector = ctl_r.sbox_sel;
  assign bus.LoadKeySchedule   = ctl_r.load_ks;
  assign bus.ShowRcon          = ctl_r.show_rcon;
  assign bus.DoSR              = ctl_r.do_sr;
  // The key register must capture while the sequencer is held in reset.
  assign bus.KeyRegEn          = rst | ctl_r.key_en;
  assign bus.Rcon              = rcon_r;
  assign bus.Round             = round_r;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: default build (5/10) and a 7/14 instance.
module tb_aes_round_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  aes_round_sequencer_if bus0();
  aes_round_sequencer_if bus1();

  aes_round_sequencer dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  aes_round_sequencer #(.SBOX_LATENCY(7), .NR(14)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  always #5 clk = ~clk;

  // order: KeyMuxSel InputMuxSel FinalRound StateEN SboxInputSelector LoadKeySchedule ShowRcon DoSR KeyRegEn
  logic [8:0] ctl0, ctl1;
  assign ctl0 = {bus0.KeyMuxSel, bus0.InputMuxSel, bus0.FinalRound, bus0.StateEN,
                 bus0.SboxInputSelector, bus0.LoadKeySchedule, bus0.ShowRcon, bus0.DoSR, bus0.KeyRegEn};
  assign ctl1 = {bus1.KeyMuxSel, bus1.InputMuxSel, bus1.FinalRound, bus1.StateEN,
                 bus1.SboxInputSelector, bus1.LoadKeySchedule, bus1.ShowRcon, bus1.DoSR, bus1.KeyRegEn};

  logic [7:0] rcon_tab [14] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                               8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after the edge that accepted start (k>=1).
  task automatic chk_run(input string tag, input int k, input int len, input int nr,
                         input logic obs_busy, input logic obs_done, input logic [3:0] obs_round,
                         input logic [7:0] obs_rcon, input logic [8:0] obs_ctl);
    bit run;
    int ph;
    int rnd;
    logic [8:0] ectl;
    run = (k >= 1) && (k <= len * nr);
    ph  = run ? (k - 1) % len : 0;
    rnd = run ? (k - 1) / len + 1 : 0;
    if (run)
      ectl = {rnd == 1 && ph < 2, rnd == 1, rnd == nr, 1'b1, ph == 2,
              ph == 0 || ph == len - 1, ph == len - 1, (ph % 2 == 1) && (ph < len - 1), ph != 2};
    else
      ectl = 9'b0;
    chk($sformatf("%s k=%0d busy", tag, k), {31'b0, obs_busy}, {31'b0, run});
    chk($sformatf("%s k=%0d done", tag, k), {31'b0, obs_done}, (k == len * nr + 1) ? 32'd1 : 32'd0);
    chk($sformatf("%s k=%0d Round", tag, k), {28'b0, obs_round}, rnd);
    chk($sformatf("%s k=%0d ctl", tag, k), {23'b0, obs_ctl}, {23'b0, ectl});
    if (run && ph == 0)
      chk($sformatf("%s k=%0d Rcon", tag, k), {24'b0, obs_rcon}, {24'b0, rcon_tab[rnd-1]});
    else if (!run)
      chk($sformatf("%s k=%0d Rcon", tag, k), {24'b0, obs_rcon}, 32'h01);
  endtask

  task automatic chk0(input string tag, input int k);
    chk_run(tag, k, 7, 10, bus0.busy, bus0.done, bus0.Round, bus0.Rcon, ctl0);
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    tick();
    tick();
    chk("rst KeyRegEn", {31'b0, bus0.KeyRegEn}, 32'd1);
    chk("rst busy", {31'b0, bus0.busy}, 32'd0);
    chk("rst Round", {28'b0, bus0.Round}, 32'd0);
    chk("rst Rcon", {24'b0, bus0.Rcon}, 32'h01);
    chk("rst done", {31'b0, bus0.done}, 32'd0);
    rst = 1'b0;
    #1;
    chk("idle KeyRegEn", {31'b0, bus0.KeyRegEn}, 32'd0);
    chk("idle ctl", {23'b0, ctl0}, 32'd0);

    // Single block, one-cycle start pulse.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int k = 1; k <= 73; k++) begin
      chk0("blk", k);
      tick();
    end

    // start raised during the final phase of round NR.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int k = 1; k <= 69; k++) begin
      chk0("b2b", k);
      tick();
    end
    chk0("b2b", 70);
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk("b2b k=71 done", {31'b0, bus0.done}, 32'd1);
`ifdef AES_SEQ_BACK_TO_BACK_EN
    chk("b2b k=71 busy", {31'b0, bus0.busy}, 32'd1);
    chk("b2b k=71 Round", {28'b0, bus0.Round}, 32'd1);
    chk("b2b k=71 Rcon", {24'b0, bus0.Rcon}, 32'h01);
    tick();
    for (int k = 2; k <= 73; k++) begin
      chk0("b2b2", k);
      tick();
    end
`else
    chk("b2b k=71 busy", {31'b0, bus0.busy}, 32'd0);
    chk("b2b k=71 Round", {28'b0, bus0.Round}, 32'd0);
    tick();
    chk("b2b k=72 busy", {31'b0, bus0.busy}, 32'd0);
    chk("b2b k=72 done", {31'b0, bus0.done}, 32'd0);
`endif

    // Reset at round 4 phase 3, then restart.
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      chk0("abort", k);
      if (k < 25) tick();
    end
    rst = 1'b1;
    #1;
    chk("abort rst KeyRegEn", {31'b0, bus0.KeyRegEn}, 32'd1);
    tick();
    rst = 1'b0;
    chk("abort busy", {31'b0, bus0.busy}, 32'd0);
    chk("abort Rcon", {24'b0, bus0.Rcon}, 32'h01);
    chk("abort Round", {28'b0, bus0.Round}, 32'd0);
    chk("abort done", {31'b0, bus0.done}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort no done", {31'b0, bus0.done}, 32'd0);
      chk("abort idle", {31'b0, bus0.busy}, 32'd0);
    end
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    chk0("restart", 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // start held high across two blocks.
    bus0.start = 1'b1;
    tick();
`ifdef AES_SEQ_BACK_TO_BACK_EN
    for (int k = 1; k <= 70; k++) begin
      chk0("held", k);
      tick();
    end
    bus0.start = 1'b0;
    chk("held k=71 done", {31'b0, bus0.done}, 32'd1);
    chk("held k=71 busy", {31'b0, bus0.busy}, 32'd1);
    chk("held k=71 Round", {28'b0, bus0.Round}, 32'd1);
    tick();
    for (int k = 2; k <= 71; k++) begin
      chk0("held2", k);
      tick();
    end
`else
    for (int k = 1; k <= 142; k++) begin
      if (k == 142) bus0.start = 1'b0;
      chk0("held", (k <= 71) ? k : k - 71);
      tick();
    end
    chk0("held end", 72);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // SBOX_LATENCY=7, NR=14 instance.
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      chk_run("p14", k, 9, 14, bus1.busy, bus1.done, bus1.Round, bus1.Rcon, ctl1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 Parameter SBOX_LATENCY, default 5; pipeline depth of the masked BRAM S-box in cycles; legal range 3..14.
REQ-002 Parameter NR, default 10; number of AES rounds per block; legal range 1..14.
REQ-003 Derived constant ROUND_LEN = SBOX_LATENCY+2; cycles per round; phase counter sized ceil(log2(ROUND_LEN)).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  request to begin one block encryption.
REQ-007 busy  out  1  high while a block is in progress.
REQ-008 done  out  1  one-cycle pulse after the last cycle of round NR.
REQ-009 KeyMuxSel / InputMuxSel / FinalRound / StateEN / SboxInputSelector / LoadKeySchedule / ShowRcon / DoSR  out  1 each  datapath controls.
REQ-010 KeyRegEn  out  1  key register enable; combinationally 1 whenever rst=1.
REQ-011 Rcon  out  8  current round constant.
REQ-012 Round  out  4  current round index, 1..NR while busy, 0 in IDLE.

Function
REQ-013 FSM states IDLE and RUN; IDLE->RUN on start=1; RUN->IDLE after phase ROUND_LEN-1 of round NR.
REQ-014 Entry to RUN: Round=1, phase=0, Rcon=8'h01; busy=1 from that cycle.
REQ-015 In RUN, phase increments each cycle; at phase ROUND_LEN-1 with Round<NR: phase->0, Round+1, Rcon->xtime(Rcon) (shift left, XOR 8'h1B if bit7 set).
REQ-016 done registered: high exactly one cycle, the cycle after final phase of round NR; no done on abort by rst.
REQ-017 IDLE outputs: StateEN=0, KeyRegEn=0 (rst=0), all other controls 0, Rcon=8'h01, Round=0.
REQ-018 RUN: StateEN=1; DoSR=1 on odd phases below ROUND_LEN-1.
REQ-019 RUN: SboxInputSelector=1 and KeyRegEn=0 at phase 2 only; KeyRegEn=1 at all other RUN phases.
REQ-020 RUN: LoadKeySchedule=1 at phases 0 and ROUND_LEN-1; ShowRcon=1 at phase ROUND_LEN-1.
REQ-021 RUN, Round=1: InputMuxSel=1 all phases; KeyMuxSel=1 at phases 0 and 1.
REQ-022 FinalRound=1 throughout round NR; 0 elsewhere.
REQ-023 start while busy is ignored unless REQ-027 applies; start held high in IDLE triggers exactly one block per acceptance.

Reset
REQ-024 rst=1 at any clock edge, including mid-round: next cycle IDLE, phase=0, Round=0, Rcon=8'h01, busy=0, done=0.
REQ-025 rst dominates start in the same cycle; start sampled only when rst=0.
REQ-026 Out-of-range SBOX_LATENCY or NR: elaboration-time error.

Configuration
REQ-027 Macro AES_SEQ_BACK_TO_BACK_EN defined: start=1 during final phase of round NR goes directly to RUN Round=1 phase=0, Rcon=8'h01, busy stays 1, done still pulses; not defined: FSM always passes through IDLE for at least one cycle, start at that phase ignored.

Verification
REQ-028 Defaults, start=1 for one cycle at cycle 0 -> busy cycles 1..70, done=1 at cycle 71 only, FinalRound cycles 64..70.
REQ-029 Defaults, sample Rcon at each round phase 0 -> 01,02,04,08,10,20,40,80,1B,36.
REQ-030 SBOX_LATENCY=7, NR=14 -> ROUND_LEN=9, DoSR at phases 1,3,5,7, KeyRegEn=0 at phase 2, done at cycle 127.
REQ-031 rst=1 at round 4 phase 3 -> next cycle busy=0, Rcon=01, Round=0, no done; new start restarts at Round=1.
REQ-032 Start high at cycle 70 -> with AES_SEQ_BACK_TO_BACK_EN: done at 71 and Round=1 at 71; without: start ignored, busy=0 at 71.
REQ-033 Start held high continuously, no macro -> blocks separated by exactly one IDLE cycle; done once per block.
